// File: rtl/shmem_pkg.sv
// Shared definitions for the banked shared scratchpad: default sizing,
// address/size types and the bank/row address split.
package shmem_pkg;

    localparam int unsigned DEF_PORT_COUNT = 4;
    localparam int unsigned DEF_BANK_COUNT = 2;
    localparam int unsigned DEF_BUS_SIZE   = 160;
    localparam int unsigned DEF_UNIT_SIZE  = 32;
    localparam int unsigned DEF_MEM_SIZE   = 1024;
    localparam int unsigned DEF_ADDR_SIZE  = 24;

    localparam int unsigned UNITS = DEF_BUS_SIZE / DEF_UNIT_SIZE;

    typedef logic [DEF_ADDR_SIZE-1:0] addr_t;
    typedef logic [2:0]               wr_size_t;

    // Low address bits select the bank (interleaved); zero bits means one bank.
    function automatic addr_t bank_of(input addr_t addr, input int unsigned bank_bits);
        return addr & addr_t'((32'd1 << bank_bits) - 32'd1);
    endfunction

    // Remaining upper bits form the row inside the selected bank.
    function automatic addr_t row_of(input addr_t addr, input int unsigned bank_bits);
        return addr >> bank_bits;
    endfunction

endpackage

// File: rtl/rr_bank_arbiter.sv
// Round-robin arbiter for one memory bank: grants the first requester at or
// after its pointer (wrapping) and advances the pointer past the winner.
module rr_bank_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] cand;
    logic             hit;

    // Scan requesters starting at rr_ptr; grant is forced low while in reset.
    always_comb begin
        grant  = '0;
        hit    = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % N_REQ);
            if (!hit && req[cand]) begin
                hit    = 1'b1;
                winner = cand;
            end
        end
        if (hit && rst_n) begin
            grant[winner] = 1'b1;
        end
    end

    // Move the pointer just past the winner; hold when nobody was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (hit) begin
            rr_ptr <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

endmodule

// File: rtl/banked_shared_mem.sv
// Multi-bank shared scratchpad: BANK_COUNT interleaved banks, each with its
// own round-robin arbiter, so processors hitting different banks are served
// in the same cycle. Reads return registered data one cycle after grant.
module banked_shared_mem
    import shmem_pkg::*;
#(
    parameter int unsigned PORT_COUNT = DEF_PORT_COUNT,
    parameter int unsigned BANK_COUNT = DEF_BANK_COUNT,
    parameter int unsigned BUS_SIZE   = DEF_BUS_SIZE,
    parameter int unsigned UNIT_SIZE  = DEF_UNIT_SIZE,
    parameter int unsigned MEM_SIZE   = DEF_MEM_SIZE,
    parameter int unsigned ADDR_SIZE  = DEF_ADDR_SIZE
) (
    input  logic                                 i_clk,
    input  logic                                 i_rstn,
    input  logic [PORT_COUNT-1:0]                i_req,
    input  logic [PORT_COUNT-1:0]                i_we,
    input  logic [PORT_COUNT-1:0][ADDR_SIZE-1:0] i_addr,
    input  logic [PORT_COUNT-1:0][BUS_SIZE-1:0]  i_wr_data,
    input  wr_size_t [PORT_COUNT-1:0]            i_wr_size,
    output logic [PORT_COUNT-1:0]                o_grant,
    output logic [PORT_COUNT-1:0][BUS_SIZE-1:0]  o_rd_data,
    output logic [PORT_COUNT-1:0]                o_rd_valid,
    output logic [PORT_COUNT-1:0]                o_err
);

    localparam int unsigned BANK_BITS = $clog2(BANK_COUNT);
    localparam int unsigned BANK_W    = (BANK_COUNT > 1) ? BANK_BITS : 1;
    localparam int unsigned ROWS      = MEM_SIZE / BANK_COUNT;
    localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned N_UNITS   = BUS_SIZE / UNIT_SIZE;

    logic [BANK_W-1:0]                     port_bank [PORT_COUNT];
    logic [ADDR_SIZE-1:0]                  port_row  [PORT_COUNT];
    logic [PORT_COUNT-1:0]                 in_range;
    logic [BANK_COUNT-1:0][PORT_COUNT-1:0] bank_req;
    logic [BANK_COUNT-1:0][PORT_COUNT-1:0] bank_grant;
    logic [BANK_COUNT-1:0][BUS_SIZE-1:0]   bank_rd;

    // Split each port address into bank and row and flag rows past the end.
    always_comb begin
        for (int unsigned p = 0; p < PORT_COUNT; p++) begin
            port_bank[p] = BANK_W'(bank_of(addr_t'(i_addr[p]), BANK_BITS));
            port_row[p]  = ADDR_SIZE'(row_of(addr_t'(i_addr[p]), BANK_BITS));
            in_range[p]  = port_row[p] < ADDR_SIZE'(ROWS);
        end
    end

    // Route each request to the arbiter of the bank it addresses.
    always_comb begin
        for (int unsigned b = 0; b < BANK_COUNT; b++) begin
            for (int unsigned p = 0; p < PORT_COUNT; p++) begin
                bank_req[b][p] = i_req[p] && (port_bank[p] == BANK_W'(b));
            end
        end
    end

    // A port is granted by at most one bank, so OR the bank grants together.
    always_comb begin
        o_grant = '0;
        for (int unsigned b = 0; b < BANK_COUNT; b++) begin
            o_grant = o_grant | bank_grant[b];
        end
    end

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic [BUS_SIZE-1:0] mem [ROWS];
        logic                sel_wr;
        logic [ROW_W-1:0]    sel_row;
        logic [BUS_SIZE-1:0] sel_data;
        wr_size_t            sel_size;

        rr_bank_arbiter #(
            .N_REQ (PORT_COUNT)
        ) u_arb (
            .clk   (i_clk),
            .rst_n (i_rstn),
            .req   (bank_req[b]),
            .grant (bank_grant[b])
        );

        // Steer the single granted port's fields onto this bank; out-of-range rows park on row 0.
        always_comb begin
            sel_wr   = 1'b0;
            sel_row  = '0;
            sel_data = '0;
            sel_size = '0;
            for (int unsigned p = 0; p < PORT_COUNT; p++) begin
                if (bank_grant[b][p]) begin
                    sel_wr   = i_we[p] && in_range[p];
                    sel_row  = in_range[p] ? ROW_W'(port_row[p]) : '0;
                    sel_data = i_wr_data[p];
                    sel_size = i_wr_size[p];
                end
            end
        end

        // Unit-masked write: the low k units, or the whole block when k is 0 or too large.
        always_ff @(posedge i_clk) begin
            if (sel_wr) begin
                for (int unsigned u = 0; u < N_UNITS; u++) begin
                    if (sel_size == '0 || 32'(sel_size) >= N_UNITS || u < 32'(sel_size)) begin
                        mem[sel_row][u*UNIT_SIZE +: UNIT_SIZE] <= sel_data[u*UNIT_SIZE +: UNIT_SIZE];
                    end
                end
            end
        end

        assign bank_rd[b] = mem[sel_row];
    end

    // Register read data, valid and error one cycle after the grant; data holds otherwise.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rd_valid <= '0;
            o_err      <= '0;
            o_rd_data  <= '0;
        end else begin
            for (int unsigned p = 0; p < PORT_COUNT; p++) begin
                o_rd_valid[p] <= o_grant[p] && !i_we[p];
                o_err[p]      <= o_grant[p] && !in_range[p];
                if (o_grant[p] && !i_we[p]) begin
                    o_rd_data[p] <= in_range[p] ? bank_rd[port_bank[p]] : '0;
                end
            end
        end
    end

endmodule

// File: doc/banked_shared_mem.md
Name: banked_shared_mem

Overview:
Multi-bank shared scratchpad for the SIMD processors. It generalises the single-port-pair shared memory to BANK_COUNT interleaved banks, each with its own round-robin arbiter. Non-conflicting processors are therefore served in the same cycle. Each port has one req/grant handshake covering both reads and writes, plus registered read data with a valid strobe.

Parameters:
PORT_COUNT, 4, number of processor ports (>=2)
BANK_COUNT, 2, number of banks; power of two, >=1
BUS_SIZE, 160, block width in bits; multiple of UNIT_SIZE
UNIT_SIZE, 32, write granule width in bits
MEM_SIZE, 1024, total blocks across all banks; multiple of BANK_COUNT
ADDR_SIZE, 24, block address width

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_req  in  PORT_COUNT  access request, held until granted
i_we  in  PORT_COUNT  1 = write, 0 = read; qualified by i_req
i_addr  in  PORT_COUNT x ADDR_SIZE  block address (addr_t)
i_wr_data  in  PORT_COUNT x BUS_SIZE  write block
i_wr_size  in  PORT_COUNT x 3  number of units to write
o_grant  out  PORT_COUNT  access accepted this cycle (combinational)
o_rd_data  out  PORT_COUNT x BUS_SIZE  read block
o_rd_valid  out  PORT_COUNT  o_rd_data valid
o_err  out  PORT_COUNT  granted access was out of range (1-cycle pulse)

Behaviour:
- Address map:
  - bank = i_addr[log2(BANK_COUNT)-1:0]; row = i_addr >> log2(BANK_COUNT).
  - Rows per bank: ROWS = MEM_SIZE/BANK_COUNT.
  - BANK_COUNT=1 means bank 0 only, with row = i_addr.
- Arbitration:
  - Each bank has one access per cycle.
  - Its arbiter considers the ports with i_req high and a matching bank.
  - It grants the first such port at or after rr_ptr[bank], scanning upward with wrap.
  - o_grant is combinational in the same cycle.
  - Per port, at most one bank matches, so o_grant is one-hot per bank.
- Pointer update: on a grant to port p, rr_ptr[bank] <= (p+1) mod PORT_COUNT. With no grant the pointer holds.
- Ungranted requester: keeps i_req and its fields stable and retries next cycle. A requester is never starved (fairness bound = PORT_COUNT-1 cycles of wait).
- Write: on grant with i_we=1 and row < ROWS, units [k-1:0] of i_wr_data are written at the rising edge.
  - k = i_wr_size.
  - k=0 or k >= BUS_SIZE/UNIT_SIZE writes the full block.
  - Upper units stay unchanged.
- Read: on grant with i_we=0, the row is read. On the next cycle, o_rd_valid[p]=1 and o_rd_data[p] = the stored block. Latency is exactly 1 cycle.
- Same bank, same cycle read vs write: impossible (one grant per bank).
- Cross-cycle ordering: a read granted the cycle after a write to the same row returns the new data.
- o_rd_data holds its last value while o_rd_valid=0.
- Out of range (row >= ROWS): the write is dropped; a read returns all-zero data with o_rd_valid=1. In both cases o_err[p]=1 one cycle after the grant.
- Reset, applied asynchronously:
  - o_rd_valid=0, o_err=0, o_rd_data=0, all rr_ptr=0.
  - Memory contents are not reset.
  - A reset asserted mid-access cancels any pending read valid.
  - o_grant is 0 whenever i_rstn=0.

Decomposition:
- Package shmem_pkg:
  - addr_t (logic [ADDR_SIZE-1:0]), wr_size_t (logic [2:0]).
  - Function bank_of(addr) / row_of(addr).
  - Constant UNITS = BUS_SIZE/UNIT_SIZE.
- Sub-module rr_bank_arbiter (N_REQ=PORT_COUNT):
  - Inputs: request vector, clock, reset.
  - Outputs: one-hot grant; owns its rr_ptr.
  - Instantiated BANK_COUNT times in a generate loop.
- Bank storage is an inline per-bank array with unit-masked write.

Test Plan:
- Reset state, then idle: o_grant=0, o_rd_valid=0, o_rd_data=0, o_err=0 for 3 cycles.
- Port 0 writes block 0xA..A at addr 4 with wr_size=0; port 1 reads addr 4 the next cycle. Port 1 is granted immediately; one cycle later o_rd_valid[1]=1 and o_rd_data[1]=0xA..A.
- Partial write: full write of all-ones to addr 6, then write of zeros with wr_size=2. A read returns units 4..2 all-ones and units 1..0 zero.
- Ports 0-3 all request bank 0 continuously. Grants go 0,1,2,3,0 on consecutive cycles, and each read returns its own address's data.
- Parallel banks: port 0 reads addr 2 (bank 0) while port 1 reads addr 3 (bank 1). Both are granted in the same cycle and both valids are asserted the following cycle.
- Out of range: a write to addr ≥1024 gives o_err pulse=1 and a later read of the aliased row is unchanged. Asserting i_rstn=0 the cycle after a read grant gives o_rd_valid=0 immediately.
